// File: rtl/vga_scanout_if.sv
// vga_scanout_if: read port between the scanout engine and the video RAM.
// The scanout side (master) presents a pixel index every clk; the RAM side
// (slave) returns the stored {R,G,B} word for that index.
interface vga_scanout_if;
  logic [14:0] mem_addr;
  logic [23:0] mem_rdata;

  modport master (output mem_addr, input mem_rdata);
  modport slave  (input mem_addr, output mem_rdata);
endinterface

// File: rtl/vga_scanout.sv
// vga_scanout: 640x480@60 read-side engine for the 160x120 video memory.
// Generates VGA timing, fetches each stored pixel through the RAM's second
// port and upscales it 4x4 onto the DAC pins. Never writes memory.
// Optional feature macro: VGA_FRAME_IRQ_EN (start-of-vblank pulse plus a
// 16-bit frame counter); when undefined frame_irq is tied low.
module vga_scanout #(
  parameter int CLK_DIV     = 2,
  parameter int H_VIS       = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_VIS       = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int FB_W        = 160,
  parameter int SCALE_SHIFT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          scan_en,
  vga_scanout_if.master mem,
  output logic          vga_hs,
  output logic          vga_vs,
  output logic [7:0]    vga_r,
  output logic [7:0]    vga_g,
  output logic [7:0]    vga_b,
  output logic          vga_blank_n,
  output logic          frame_irq
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS_C  = HW'(H_VIS);
  localparam logic [HW-1:0] HS_BEGIN = HW'(H_VIS + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_VIS + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS_C  = VW'(V_VIS);
  localparam logic [VW-1:0] V_VIS_L  = VW'(V_VIS - 1);
  localparam logic [VW-1:0] VS_BEGIN = VW'(V_VIS + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_VIS + V_FP + V_SYNC);

  logic [DW-1:0] div;
  logic          tick;
  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic          visible;
  logic          hs_raw;
  logic          vs_raw;
  logic [HW-1:0] xs;
  logic [VW-1:0] ys;
  logic [14:0]   row_base;
  logic [14:0]   addr_next;
  logic [23:0]   s1_data;
  logic          s1_vis;
  logic          s1_hs;
  logic          s1_vs;

  assign tick = (div == DIV_LAST);

  // Free-running clock divider; tick marks the last system clk of a pixel
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     div <= '0;
    else if (tick) div <= '0;
    else           div <= div + 1'b1;
  end

  // Raster counters; both wrap together at the end of the last line
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (tick) begin
      if (hcnt == H_LAST) begin
        hcnt <= '0;
        vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
      end else begin
        hcnt <= hcnt + 1'b1;
      end
    end
  end

  // Stage 0: visible window and raw (active-low) syncs from the counters
  always_comb begin
    visible = (hcnt < H_VIS_C) && (vcnt < V_VIS_C);
    hs_raw  = !((hcnt >= HS_BEGIN) && (hcnt < HS_END));
    vs_raw  = !((vcnt >= VS_BEGIN) && (vcnt < VS_END));
  end

  assign xs = hcnt >> SCALE_SHIFT;
  assign ys = vcnt >> SCALE_SHIFT;

  // Row base = ys * FB_W; for the native 160-wide buffer this is two shifts
  generate
    if (FB_W == 160) begin : g_row160
      assign row_base = (15'(ys) << 7) + (15'(ys) << 5);
    end else begin : g_rowgen
      assign row_base = 15'(32'(ys) * FB_W);
    end
  endgenerate

  assign addr_next = visible ? row_base + 15'(xs) : '0;

  // Address is refreshed every clk so the read data settles before the next tick
  always_ff @(posedge clk or posedge reset) begin
    if (reset) mem.mem_addr <= '0;
    else       mem.mem_addr <= addr_next;
  end

  // Stage 1: capture the fetched pixel together with its timing flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_data <= '0;
      s1_vis  <= 1'b0;
      s1_hs   <= 1'b1;
      s1_vs   <= 1'b1;
    end else if (tick) begin
      s1_data <= mem.mem_rdata;
      s1_vis  <= visible;
      s1_hs   <= hs_raw;
      s1_vs   <= vs_raw;
    end
  end

  // Stage 2: registered DAC outputs; scan_en gates colour but never the syncs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vga_hs                  <= 1'b1;
      vga_vs                  <= 1'b1;
      vga_blank_n             <= 1'b0;
      {vga_r, vga_g, vga_b}   <= '0;
    end else if (tick) begin
      vga_hs                  <= s1_hs;
      vga_vs                  <= s1_vs;
      vga_blank_n             <= s1_vis & scan_en;
      {vga_r, vga_g, vga_b}   <= (s1_vis && scan_en) ? s1_data : '0;
    end
  end

`ifdef VGA_FRAME_IRQ_EN
  logic [15:0] frame_cnt;
  logic        vblank_start;

  assign vblank_start = tick && (hcnt == H_LAST) && (vcnt == V_VIS_L);

  // One-clk pulse and frame count on the tick that enters vertical blanking
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_irq <= 1'b0;
      frame_cnt <= '0;
    end else begin
      frame_irq <= vblank_start;
      if (vblank_start) frame_cnt <= frame_cnt + 16'd1;
    end
  end
`else
  assign frame_irq = 1'b0;
`endif

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: self-checking bench for vga_scanout.
// Runs the real 800-pixel line with a shortened 14-line frame so several
// frames fit in a short run. A raster model derived from x/y arithmetic
// predicts every output on every clk; a probe table pins down specific
// pixels, and hand sequences cover sync counts, mid-frame reset and irq.
module tb_vga_scanout;

  localparam int HT       = 800;
  localparam int VT       = 14;
  localparam int HVIS     = 640;
  localparam int VVIS     = 8;
  localparam int HS0      = 656;
  localparam int HS1      = 752;
  localparam int VS0      = 10;
  localparam int VS1      = 12;
  localparam int FRAME_T  = HT * VT;
  localparam int FRAME_C  = 2 * FRAME_T;
  localparam int IRQ_TICK = HT * VVIS - 1;
  localparam logic [26:0] RESET_OUT = {1'b1, 1'b1, 1'b0, 24'h0};
`ifdef VGA_FRAME_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       scan_en;
  logic       vga_hs, vga_vs, vga_blank_n, frame_irq;
  logic [7:0] vga_r, vga_g, vga_b;

  logic [23:0] ram [0:32767];

  vga_scanout_if bus ();

  assign bus.mem_rdata = ram[bus.mem_addr];

  vga_scanout #(
    .V_VIS  (VVIS),
    .V_FP   (2),
    .V_SYNC (2),
    .V_BP   (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .scan_en     (scan_en),
    .mem         (bus),
    .vga_hs      (vga_hs),
    .vga_vs      (vga_vs),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .vga_blank_n (vga_blank_n),
    .frame_irq   (frame_irq)
  );

  // 100 MHz-style bench clock; only the ratio to the pixel tick matters
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic en, input int clks);
    scan_en = en;
    repeat (clks) @(negedge clk);
  endtask

  // Output pins for raster pixel index p (p<0 means pipeline still empty)
  function automatic logic [26:0] model_out(input int p, input logic en);
    int x, y;
    logic vis;
    logic [23:0] rgb;
    if (p < 0) return RESET_OUT;
    x   = p % HT;
    y   = (p / HT) % VT;
    vis = (x < HVIS) && (y < VVIS);
    rgb = (vis && en) ? ram[(y / 4) * 160 + x / 4] : 24'h0;
    return {(x < HS0 || x >= HS1), (y < VS0 || y >= VS1), vis && en, rgb};
  endfunction

  // RAM index requested while the raster sits on index idx
  function automatic logic [14:0] model_addr(input int idx);
    int x, y;
    x = idx % HT;
    y = (idx / HT) % VT;
    if (x < HVIS && y < VVIS) return 15'((y / 4) * 160 + x / 4);
    return 15'd0;
  endfunction

  // Per-clk scoreboard state
  int          n = 0;
  int          t;
  logic        en_s;
  logic        tick_en = 1'b0;
  logic        cap_on = 1'b0;
  logic [26:0] cap [0:FRAME_T-1];
  logic [26:0] act_o, exp_o;
  logic [14:0] exp_addr;
  logic        exp_irq;
  int          hs_low_clks = 0;
  int          vs_low_clks = 0;
  int          blank_clks = 0;
  int          irq_pulses = 0;

  // Every clk: advance the model one system clock and compare all outputs
  always @(posedge clk) begin
    en_s = scan_en;
    #1;
    act_o = {vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b};
    if (reset) begin
      n        = 0;
      exp_o    = RESET_OUT;
      exp_addr = 15'd0;
      exp_irq  = 1'b0;
    end else begin
      n++;
      if (n % 2 == 0) tick_en = en_s;
      t        = n / 2;
      exp_o    = (t == 0) ? RESET_OUT : model_out(t - 2, tick_en);
      exp_addr = model_addr((n - 1) / 2);
      exp_irq  = IRQ_ON && (n % 2 == 0) && (((t - 1) % FRAME_T) == IRQ_TICK);
      if (cap_on && (n % 2 == 0) && t >= 2 && (t - 2) < FRAME_T) cap[t - 2] = act_o;
      if (!vga_hs) hs_low_clks++;
      if (!vga_vs) vs_low_clks++;
      if (vga_blank_n) blank_clks++;
      if (frame_irq) irq_pulses++;
    end
    checkOutput("pixel_out", 32'(act_o), 32'(exp_o));
    checkOutput("mem_addr", 32'(bus.mem_addr), 32'(exp_addr));
    checkOutput("frame_irq", 32'(frame_irq), 32'(exp_irq));
  end

  typedef struct {
    int          x;
    int          y;
    logic [23:0] rgb;
    logic        blank_n;
    logic        hs;
    logic        vs;
  } probe_t;

  probe_t probes [14];
  int     edges;

  initial begin
    reset   = 1'b1;
    scan_en = 1'b1;
    for (int i = 0; i < 32768; i++) ram[i] = 24'($urandom);
    ram[0]   = 24'hFF0000;
    ram[1]   = 24'h00FF00;
    ram[319] = 24'h123456;

    probes[0]  = '{0,   0,  24'hFF0000, 1'b1, 1'b1, 1'b1};
    probes[1]  = '{3,   0,  24'hFF0000, 1'b1, 1'b1, 1'b1};
    probes[2]  = '{4,   0,  24'h00FF00, 1'b1, 1'b1, 1'b1};
    probes[3]  = '{7,   3,  24'h00FF00, 1'b1, 1'b1, 1'b1};
    probes[4]  = '{3,   3,  24'hFF0000, 1'b1, 1'b1, 1'b1};
    probes[5]  = '{639, 7,  24'h123456, 1'b1, 1'b1, 1'b1};
    probes[6]  = '{640, 0,  24'h000000, 1'b0, 1'b1, 1'b1};
    probes[7]  = '{656, 0,  24'h000000, 1'b0, 1'b0, 1'b1};
    probes[8]  = '{751, 5,  24'h000000, 1'b0, 1'b0, 1'b1};
    probes[9]  = '{752, 5,  24'h000000, 1'b0, 1'b1, 1'b1};
    probes[10] = '{0,   10, 24'h000000, 1'b0, 1'b1, 1'b0};
    probes[11] = '{799, 11, 24'h000000, 1'b0, 1'b1, 1'b0};
    probes[12] = '{0,   12, 24'h000000, 1'b0, 1'b1, 1'b1};
    probes[13] = '{655, 9,  24'h000000, 1'b0, 1'b1, 1'b1};

    repeat (3) @(negedge clk);
    cap_on = 1'b1;
    hs_low_clks = 0; vs_low_clks = 0; blank_clks = 0; irq_pulses = 0;
    reset = 1'b0;

    // Frame 1: full colour
    applyStimulus(1'b1, FRAME_C);
    cap_on = 1'b0;
    checkOutput("f1_hs_low_clks", hs_low_clks, 32'(VT * (HS1 - HS0) * 2));
    checkOutput("f1_vs_low_clks", vs_low_clks, 32'((VS1 - VS0) * HT * 2));
    checkOutput("f1_blank_clks", blank_clks, 32'(HVIS * VVIS * 2));
    checkOutput("f1_irq_pulses", irq_pulses, IRQ_ON ? 32'd1 : 32'd0);
    for (int i = 0; i < 14; i++) begin
      checkOutput($sformatf("probe_x%0d_y%0d", probes[i].x, probes[i].y),
                  32'(cap[probes[i].y * HT + probes[i].x]),
                  32'({probes[i].hs, probes[i].vs, probes[i].blank_n, probes[i].rgb}));
    end

    // Frame 2: scan disabled, timing must be unchanged
    hs_low_clks = 0; vs_low_clks = 0; blank_clks = 0; irq_pulses = 0;
    applyStimulus(1'b0, FRAME_C);
    checkOutput("f2_hs_low_clks", hs_low_clks, 32'(VT * (HS1 - HS0) * 2));
    checkOutput("f2_vs_low_clks", vs_low_clks, 32'((VS1 - VS0) * HT * 2));
    checkOutput("f2_blank_clks", blank_clks, 32'd0);
    checkOutput("f2_irq_pulses", irq_pulses, IRQ_ON ? 32'd1 : 32'd0);
`ifdef VGA_FRAME_IRQ_EN
    checkOutput("frame_cnt_after_2", 32'(dut.frame_cnt), 32'd2);
`endif

    // Frame 3: random scan_en toggles up to raster (300,2)
    for (int i = 0; i < 2 * (2 * HT + 300) - 20; i++) begin
      if ($urandom_range(0, 15) == 0) scan_en = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    applyStimulus(1'b1, 20);
    checkOutput("pre_reset_blank_n", 32'(vga_blank_n), 32'd1);

    // Mid-frame asynchronous reset
    reset = 1'b1;
    #1;
    checkOutput("async_reset_pins", 32'({vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b}), 32'(RESET_OUT));
    checkOutput("async_reset_addr", 32'(bus.mem_addr), 32'd0);
`ifdef VGA_FRAME_IRQ_EN
    checkOutput("async_reset_frame_cnt", 32'(dut.frame_cnt), 32'd0);
`endif
    repeat (2) @(negedge clk);
    reset = 1'b0;
    edges = 0;
    while (edges < 3000) begin
      @(posedge clk);
      #1;
      edges++;
      if (vga_hs === 1'b0) break;
    end
    checkOutput("hs_fall_after_reset", edges, 32'(2 * (HS0 + 2)));
    @(negedge clk);

    // Random tail after reset
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 7) == 0) scan_en = 1'($urandom_range(0, 1));
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
